// File: rtl/transmissor_chave.sv
// Serial key transmitter: loads CHAVE or dado and shifts it out LSB-first with a
// bit-valid qualifier, optionally repeating frames separated by GAP idle cycles.
module transmissor_chave #(
  parameter int               NBITS = 4,
  parameter logic [NBITS-1:0] CHAVE = 4'b1101,
  parameter int               GAP   = 2
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic             start,
  input  logic             repetir,
  input  logic             usar_chave,
  input  logic [NBITS-1:0] dado,
  output logic             serial_out,
  output logic             bit_valido,
  output logic             ocupado,
  output logic             fim,
  output logic [7:0]       n_quadros
);

  localparam int CW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(NBITS - 1);
  localparam logic [CW-1:0] BIT_PEN  = CW'((NBITS > 1) ? NBITS - 2 : 0);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {OCIOSO, ENVIA, INTERVALO} estado_t;

  estado_t          estado_reg;
  logic [NBITS-1:0] sreg_reg;
  logic [CW-1:0]    cnt_reg;
  logic [GW-1:0]    gap_reg;

  logic [NBITS-1:0] palavra;
  logic             ultimo_bit;
  logic             ultimo_gap;
  logic             carrega;

  assign palavra = usar_chave ? CHAVE : dado;

  // A frame load happens from idle on start, or at a frame/gap boundary while repeating.
  always_comb begin
    ultimo_bit = (estado_reg == ENVIA) && (cnt_reg == BIT_LAST);
    ultimo_gap = (estado_reg == INTERVALO) && (gap_reg == GAP_LAST);
    carrega    = ((estado_reg == OCIOSO) && start)
               || (ultimo_bit && repetir && (GAP == 0))
               || (ultimo_gap && repetir);
  end

  always_ff @(posedge clk_2 or negedge reset) begin
    if (!reset) begin
      estado_reg <= OCIOSO;
      sreg_reg   <= '0;
      cnt_reg    <= '0;
      gap_reg    <= '0;
      serial_out <= 1'b0;
      bit_valido <= 1'b0;
      ocupado    <= 1'b0;
      fim        <= 1'b0;
      n_quadros  <= 8'd0;
    end else begin
      if (ultimo_bit)
        n_quadros <= n_quadros + 8'd1;

      if (carrega) begin
        // Bit 0 goes straight to the output register; the rest waits in sreg_reg.
        estado_reg <= ENVIA;
        sreg_reg   <= palavra >> 1;
        cnt_reg    <= '0;
        serial_out <= palavra[0];
        bit_valido <= 1'b1;
        ocupado    <= 1'b1;
        fim        <= (NBITS == 1);
      end else begin
        case (estado_reg)
          ENVIA: begin
            if (ultimo_bit) begin
              serial_out <= 1'b0;
              bit_valido <= 1'b0;
              fim        <= 1'b0;
              if (repetir) begin
                estado_reg <= INTERVALO;
                gap_reg    <= '0;
              end else begin
                estado_reg <= OCIOSO;
                ocupado    <= 1'b0;
              end
            end else begin
              serial_out <= sreg_reg[0];
              sreg_reg   <= sreg_reg >> 1;
              cnt_reg    <= cnt_reg + CW'(1);
              fim        <= (cnt_reg == BIT_PEN);
            end
          end
          INTERVALO: begin
            if (ultimo_gap) begin
              estado_reg <= OCIOSO;
              ocupado    <= 1'b0;
            end else begin
              gap_reg <= gap_reg + GW'(1);
            end
          end
          default: estado_reg <= OCIOSO;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_transmissor_chave.sv
// Bench for transmissor_chave: one instance with GAP=2 and one with GAP=0, random
// frame bursts, expected frames queued by the driver and checked by a monitor.
module tb_transmissor_chave;

  localparam int         NBITS = 4;
  localparam logic [3:0] KEY   = 4'b1101;

  typedef struct {
    logic [3:0] w;
    bit         first;
    int         dut;
  } exp_t;

  logic       clk_2 = 1'b0;
  logic       reset;
  logic [1:0] start_v;
  logic       repetir;
  logic       usar_chave;
  logic [3:0] dado;
  logic [1:0] so, bv, oc, fm;
  logic [7:0] nq [2];

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  logic [3:0] cur  [2];
  int         bi   [2];
  int         gapc [2];
  int         cnt  [2];

  always #5 clk_2 = ~clk_2;

  transmissor_chave #(.NBITS(4), .CHAVE(4'b1101), .GAP(2)) dut_a (
    .clk_2(clk_2), .reset(reset), .start(start_v[0]), .repetir(repetir),
    .usar_chave(usar_chave), .dado(dado), .serial_out(so[0]), .bit_valido(bv[0]),
    .ocupado(oc[0]), .fim(fm[0]), .n_quadros(nq[0])
  );

  transmissor_chave #(.NBITS(4), .CHAVE(4'b1101), .GAP(0)) dut_b (
    .clk_2(clk_2), .reset(reset), .start(start_v[1]), .repetir(repetir),
    .usar_chave(usar_chave), .dado(dado), .serial_out(so[1]), .bit_valido(bv[1]),
    .ocupado(oc[1]), .fim(fm[1]), .n_quadros(nq[1])
  );

  function automatic int gap_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, expv, $time);
    end
  endtask

  // Monitor: every cycle, for both instances, compare against the queued frames.
  always @(negedge clk_2) begin
    if (reset !== 1'b1) begin
      exp_q.delete();
      for (int d = 0; d < 2; d++) begin
        bi[d] = 0; gapc[d] = 0; cnt[d] = 0; cur[d] = 4'd0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("n_quadros[%0d]", d), nq[d], cnt[d]);
        if (bv[d] === 1'b1) begin
          if (bi[d] == 0) begin
            if (exp_q.size() == 0 || exp_q[0].dut != d) begin
              chk($sformatf("quadro_inesperado[%0d]", d), 1, 0);
              cur[d] = 4'd0;
            end else begin
              exp_t e;
              e = exp_q.pop_front();
              cur[d] = e.w;
              if (!e.first) chk($sformatf("intervalo[%0d]", d), gapc[d], gap_of(d));
            end
          end
          chk($sformatf("serial_out[%0d] bit%0d", d, bi[d]), so[d], cur[d][bi[d]]);
          chk($sformatf("fim[%0d] bit%0d", d, bi[d]), fm[d], (bi[d] == NBITS-1));
          chk($sformatf("ocupado_envio[%0d]", d), oc[d], 1);
          if (bi[d] == NBITS-1) begin
            cnt[d] = (cnt[d] + 1) % 256;
            bi[d]  = 0;
            $display("quadro dut=%0d palavra=%b n_quadros_apos=%0d", d, cur[d], cnt[d]);
          end else begin
            bi[d]++;
          end
          gapc[d] = 0;
        end else begin
          chk($sformatf("serial_out_ocioso[%0d]", d), so[d], 0);
          chk($sformatf("fim_ocioso[%0d]", d), fm[d], 0);
          chk($sformatf("ocupado_ocioso[%0d]", d), oc[d],
              (gapc[d] < gap_of(d)) && exp_q.size() > 0 && exp_q[0].dut == d && !exp_q[0].first);
          gapc[d]++;
        end
      end
    end
  end

  // forced: -1 random word, 16 = key, 0..15 = fixed dado with usar_chave=0
  task automatic burst(input int d, input int nf, input int forced);
    logic       uc_a [256];
    logic [3:0] dd_a [256];
    exp_t       e;
    int         period;
    period = NBITS + gap_of(d);
    for (int i = 0; i < nf; i++) begin
      if (forced < 0) begin
        uc_a[i] = 1'($urandom); dd_a[i] = 4'($urandom);
      end else if (forced == 16) begin
        uc_a[i] = 1'b1; dd_a[i] = 4'($urandom);
      end else begin
        uc_a[i] = 1'b0; dd_a[i] = 4'(forced);
      end
      e.w = uc_a[i] ? KEY : dd_a[i];
      e.first = (i == 0);
      e.dut = d;
      exp_q.push_back(e);
    end
    for (int i = 0; i < nf; i++) begin
      usar_chave = uc_a[i];
      dado       = dd_a[i];
      start_v    = 2'b00;
      if (i == 0) begin
        start_v[d] = 1'b1;
        repetir    = (nf > 1);
      end
      @(posedge clk_2); #1;
      if (i == 0) chk($sformatf("latencia[%0d]", d), bv[d], 1);
      if (i == nf-1) repetir = 1'b0;
      for (int c = 0; c < ((i == nf-1) ? NBITS-1 : period-1); c++) begin
        usar_chave = 1'($urandom);
        dado       = 4'($urandom);
        start_v[d] = 1'($urandom);
        @(posedge clk_2); #1;
      end
      start_v = 2'b00;
    end
    @(posedge clk_2); #1;
    repeat (2) @(posedge clk_2);
    #1;
  endtask

  initial begin
    exp_t e;
    reset = 1'b0; start_v = 2'b00; repetir = 1'b0; usar_chave = 1'b0; dado = 4'd0;
    repeat (3) @(posedge clk_2);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst serial_out[%0d]", d), so[d], 0);
      chk($sformatf("rst bit_valido[%0d]", d), bv[d], 0);
      chk($sformatf("rst ocupado[%0d]", d), oc[d], 0);
      chk($sformatf("rst fim[%0d]", d), fm[d], 0);
      chk($sformatf("rst n_quadros[%0d]", d), nq[d], 0);
    end
    reset = 1'b1;
    repeat (3) @(posedge clk_2);
    #1;

    burst(0, 1, 16);     // single key frame
    burst(0, 1, 6);      // dado 0110, scrambled after load
    burst(0, 3, 16);     // repeat with gap
    burst(1, 2, 16);     // back-to-back, 8 valid bits

    // start held high with repetir=0: three frames, one idle cycle apart
    for (int i = 0; i < 3; i++) begin
      e.w = KEY; e.first = 1'b1; e.dut = 0;
      exp_q.push_back(e);
    end
    usar_chave = 1'b1; repetir = 1'b0; start_v = 2'b01;
    @(posedge clk_2);
    repeat (10) @(posedge clk_2);
    #1;
    start_v = 2'b00;
    repeat (6) @(posedge clk_2);
    #1;

    // reset in the middle of a frame, after its second bit
    e.w = KEY; e.first = 1'b1; e.dut = 0;
    exp_q.push_back(e);
    usar_chave = 1'b1; start_v = 2'b01;
    @(posedge clk_2); #1;
    start_v = 2'b00;
    @(posedge clk_2); #1;
    @(posedge clk_2); #2;
    reset = 1'b0;
    #1;
    chk("rst_meio serial_out", so[0], 0);
    chk("rst_meio bit_valido", bv[0], 0);
    chk("rst_meio ocupado", oc[0], 0);
    chk("rst_meio fim", fm[0], 0);
    chk("rst_meio n_quadros", nq[0], 0);
    @(posedge clk_2); #1;
    reset = 1'b1;
    repeat (3) @(posedge clk_2);
    #1;

    for (int t = 0; t < 30; t++)
      burst(int'($urandom_range(1, 0)), int'($urandom_range(4, 1)), -1);

    // 256 frames from a fresh reset: the counter wraps back to 0
    reset = 1'b0;
    @(posedge clk_2); #1;
    reset = 1'b1;
    @(posedge clk_2); #1;
    burst(1, 256, -1);
    chk("wrap n_quadros", nq[1], 0);

    repeat (3) @(posedge clk_2);
    #1;
    chk("fila_vazia", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/transmissor_chave.md
Name: transmissor_chave

Overview:
- Serial key transmitter; the sending end of the 4-bit serial key detector link.
- On request it loads an NBITS-wide word (the fixed key CHAVE or the switch value dado) and shifts it out LSB-first, one bit per clk_2 cycle, with a bit-valid qualifier.
- Optionally repeats frames with a programmable idle gap between them.
- Sits in top between SWI and the detector/LED path; serial_out feeds the detector's entrada data input.

Parameters:
- NBITS, 4, frame width in bits.
- CHAVE, 4'b1101, fixed key transmitted when usar_chave=1.
- GAP, 2, idle cycles between frames in repeat mode (0 = back-to-back frames).

Ports:
- clk_2  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  frame request, sampled on rising clk_2 while idle.
- repetir  input  1  1 = keep sending frames until dropped.
- usar_chave  input  1  1 = send CHAVE, 0 = send dado; sampled at each frame load.
- dado  input  NBITS  alternate word, sampled at each frame load.
- serial_out  output  1  serial data bit, LSB first.
- bit_valido  output  1  high while serial_out carries a frame bit.
- ocupado  output  1  high in ENVIA and INTERVALO.
- fim  output  1  one-cycle pulse coincident with the last bit of each frame.
- n_quadros  output  8  count of completed frames, wraps 255->0.

Behaviour:
- Reset: asynchronous, active-low. While reset=0:
  - FSM goes to OCIOSO.
  - serial_out=0, bit_valido=0, ocupado=0, fim=0, n_quadros=0.
  - Shift register and bit counter cleared.
  - Takes effect immediately, including mid-frame or mid-gap; the partial frame is discarded and not counted.
- Registered outputs: all outputs are registered. No combinational path from inputs to outputs.
- FSM states: OCIOSO, ENVIA, INTERVALO.
- OCIOSO:
  - Outputs: serial_out=0, bit_valido=0, ocupado=0.
  - On an edge with start=1, load the shift register with CHAVE if usar_chave=1, else with dado.
  - Clear the bit counter; next state ENVIA.
- ENVIA:
  - Each cycle: serial_out=sreg[0], bit_valido=1, ocupado=1.
  - On each edge: shift right by 1 and increment the counter.
  - The frame lasts exactly NBITS cycles.
  - During the cycle presenting bit NBITS-1: fim=1, and n_quadros increments on the closing edge.
- End-of-frame decision, using repetir sampled on the last-bit edge:
  - repetir=0: go to OCIOSO.
  - repetir=1, GAP>0: go to INTERVALO.
  - repetir=1, GAP=0: reload the word on that same edge and stay in ENVIA, so the next frame's bit 0 follows with no bubble.
- INTERVALO:
  - Outputs: serial_out=0, bit_valido=0, ocupado=1, for exactly GAP cycles (gap counter).
  - On the final gap edge, repetir is re-sampled:
    - repetir=1: reload the word (re-sample usar_chave/dado) and go to ENVIA.
    - repetir=0: go to OCIOSO.
- Latency: start sampled at edge k puts bit 0 on serial_out with bit_valido=1 from edge k+1. The frame occupies cycles k+1..k+NBITS.
- start while ocupado=1 is ignored: not queued, no effect.
- Holding start=1 with repetir=0 sends one frame, returns to OCIOSO for at least 1 cycle, then starts again. Minimum spacing between back-to-back single frames is 1 idle cycle.
- Changes to dado or usar_chave mid-frame do not affect the frame in flight.
- Simultaneous events:
  - fim and the n_quadros increment occur on the same frame.
  - At wrap, n_quadros goes 255->0 with fim still pulsing.
- Consistency: with CHAVE=1101 the bit order is 1,0,1,1. A 4-bit right-shift receiver (new bit into the MSB) holds 1101 after the 4th bit.

Test Plan:
- Reset then idle: reset=0 mid-run, then release -> all outputs 0, n_quadros=0, FSM OCIOSO; no bit_valido until start.
- Single key frame: usar_chave=1, repetir=0, 1-cycle start pulse -> serial_out 1,0,1,1 on 4 consecutive cycles with bit_valido=1; fim high only on the 4th; n_quadros=1; ocupado then drops.
- Data frame with dado change: usar_chave=0, dado=4'b0110, change dado to 4'b1111 after the 1st bit -> serial_out 0,1,1,0 (original word kept).
- Repeat with gap: repetir=1, GAP=2, 3 frames then drop repetir during the 3rd frame -> pattern 1011,00,1011,00,1011; ocupado stays high throughout; fim pulses 3 times; n_quadros=3; then OCIOSO.
- Back-to-back (GAP=0): repetir=1 -> 8 consecutive bit_valido cycles 1,0,1,1,1,0,1,1; start pulses during ocupado ignored.
- Reset mid-frame and wrap: reset=0 after 2nd bit -> outputs clear immediately, no fim, count unchanged from 0. Run 256 frames -> n_quadros reads 255 then 0 on the 256th fim.
